wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage of the NPC core; sits directly upstream of the register file.
- Accepts one completed instruction per handshake from EXU/LSU and aligns and extends load data.
- Holds the result until the commit/trace consumer accepts it, then drives the register-file write port (rf_wen/rf_waddr/rf_wdata).
- Keeps a per-register pending-write scoreboard that decode queries for RAW hazards.

Parameters:
- AWIDTH, 5, register address width
- DWIDTH, 32, data width
- CNTW, 2, scoreboard counter width; counters saturate at 2**CNTW-1

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  upstream result valid
- in_ready  out  1  stage can accept a result
- in_rd  in  AWIDTH  destination register
- in_rd_wen  in  1  instruction writes rd
- in_is_load  in  1  in_result is a raw memory word
- in_load_size  in  2  0=byte, 1=half, 2=word
- in_load_unsigned  in  1  zero-extend instead of sign-extend
- in_addr_lo  in  2  load address bits [1:0]
- in_result  in  DWIDTH  ALU result or raw load word
- retire_valid  out  1  held entry is present
- retire_ready  in  1  commit/trace consumer accepts the entry
- retire_rd  out  AWIDTH  rd of the held entry
- retire_data  out  DWIDTH  final writeback value
- rf_wen  out  1  register-file write enable
- rf_waddr  out  AWIDTH  register-file write address
- rf_wdata  out  DWIDTH  register-file write data
- issue_valid  in  1  decode issues an instruction
- issue_rd  in  AWIDTH  rd of the issued instruction; x0 means no write
- issue_stall  out  1  scoreboard counter for issue_rd is saturated
- q_rs1  in  AWIDTH  hazard query address 1
- q_rs2  in  AWIDTH  hazard query address 2
- q_busy1  out  1  write to q_rs1 pending (combinational)
- q_busy2  out  1  write to q_rs2 pending (combinational)

Behaviour:
- One-entry holding register with a `full` flag.
  - in_ready = !full || retire_ready.
  - Capture when in_valid && in_ready.
  - retire_valid = full.
- Capture and retire in the same cycle: the new entry replaces the old one; full stays 1.
- Latency: a result is visible on retire_* the cycle after capture. With retire_ready held high, throughput is 1/cycle.
- Data formatting happens before capture; retire_data is registered. When in_is_load=1:
  - byte: select bits [8*addr_lo +: 8].
  - half: select the half at addr_lo[1]; addr_lo[0] is ignored.
  - word: in_result unchanged; addr_lo is ignored.
  - Sign-extend unless in_load_unsigned=1.
  - in_load_size=3 is treated as word.
- Register-file write port:
  - rf_wen = full && retire_ready && held rd_wen && (rd != 0).
  - rf_waddr = retire_rd, rf_wdata = retire_data, both combinational from the holding register.
  - The write lands on the same edge as the retire handshake.
- Scoreboard: one CNTW-bit counter per register; entry 0 is hardwired to 0.
  - Increment when issue_valid && issue_rd != 0 && !issue_stall.
  - Decrement when rf_wen fires for that register.
  - Increment and decrement on the same register in the same cycle: counter unchanged.
  - issue_stall = (cnt[issue_rd] == max); decode must hold issue.
  - A decrement at 0 is a protocol error; the counter stays at 0 (no underflow), and simulation issues an assertion failure.
- q_busy = cnt[q_rs] != 0. x0 always reads not busy.
- Reset:
  - full=0, held entry cleared, all counters 0.
  - Outputs: in_ready=1, retire_valid=0, rf_wen=0, busy/stall=0.
  - Reset mid-hold discards the entry; no register-file write occurs in the reset cycle.
- The retire handshake drives rf_wen, so a backpressured entry never writes the register file twice.

Decomposition:
- Shared package holds:
  - load-size enum (LS_B, LS_H, LS_W)
  - AWIDTH/DWIDTH constants
  - a packed wb_entry_t {rd, rd_wen, data}
- One natural sub-module: `load_align`, purely combinational (size, unsigned, addr_lo, word -> data).

Test Plan:
- Byte sign-extension: load, in_result=0x80FF7F01, size=byte, addr_lo=3, signed -> retire_data=0xFFFFFF80. Same with unsigned=1 -> 0x00000080.
- Halfword: load, size=half, addr_lo=2, word=0x8001_1234, signed -> 0xFFFF8001; addr_lo=3 gives the same value.
- Backpressure: retire_ready=0 for 3 cycles with an entry held.
  - in_ready=0, rf_wen=0 throughout.
  - On the ready cycle, exactly one rf_wen pulse with rd=5, data=0x2A.
  - Back-to-back streaming at 1/cycle afterwards.
- Scoreboard:
  - issue rd=7 twice -> q_busy1(q_rs1=7)=1.
  - Third issue -> counter reaches 3; fourth issue shows issue_stall=1.
  - Two retires of rd=7 -> counter reaches 1, busy still 1.
  - One more retire -> busy 0.
  - Same-cycle issue and retire of rd=7 leaves the count unchanged.
- x0: retire with rd=0, rd_wen=1 -> rf_wen=0. Issue rd=0 -> no count change; q_busy for x0=0.
- Reset mid-hold: entry held, retire_ready=0, assert rst with retire_ready=1 -> no rf_wen; afterwards retire_valid=0 and all busy=0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the NPC writeback stage.
package wb_stage_pkg;

  localparam int WB_AWIDTH = 5;
  localparam int WB_DWIDTH = 32;

  // Load access size; encoding 3 is not named and behaves as a word.
  typedef enum logic [1:0] {
    LS_B = 2'd0,
    LS_H = 2'd1,
    LS_W = 2'd2
  } ls_e;

  // One completed instruction waiting for retire.
  typedef struct packed {
    logic [WB_AWIDTH-1:0] rd;
    logic                 rd_wen;
    logic [WB_DWIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data alignment: picks the addressed byte/half out of the raw
// memory word and sign- or zero-extends it to the full data width.
module load_align
  import wb_stage_pkg::*;
#(
  parameter int DWIDTH = WB_DWIDTH
) (
  input  logic [1:0]        size,
  input  logic              unsigned_ext,
  input  logic [1:0]        addr_lo,
  input  logic [DWIDTH-1:0] word,
  output logic [DWIDTH-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = word[{addr_lo, 3'b000} +: 8];
  // Halfwords are naturally aligned, so only addr_lo[1] matters.
  assign h = word[{addr_lo[1], 4'b0000} +: 16];

  // Size select with extension; anything that is not byte/half is a word.
  always_comb begin
    data = word;
    case (size)
      LS_B:    data = {{(DWIDTH-8){b[7] & ~unsigned_ext}}, b};
      LS_H:    data = {{(DWIDTH-16){h[15] & ~unsigned_ext}}, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: one-entry holding register between EXU/LSU and the
// register file, plus a per-register pending-write scoreboard for decode.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int AWIDTH = WB_AWIDTH,
  parameter int DWIDTH = WB_DWIDTH,
  parameter int CNTW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AWIDTH-1:0] in_rd,
  input  logic              in_rd_wen,
  input  logic              in_is_load,
  input  logic [1:0]        in_load_size,
  input  logic              in_load_unsigned,
  input  logic [1:0]        in_addr_lo,
  input  logic [DWIDTH-1:0] in_result,
  output logic              retire_valid,
  input  logic              retire_ready,
  output logic [AWIDTH-1:0] retire_rd,
  output logic [DWIDTH-1:0] retire_data,
  output logic              rf_wen,
  output logic [AWIDTH-1:0] rf_waddr,
  output logic [DWIDTH-1:0] rf_wdata,
  input  logic              issue_valid,
  input  logic [AWIDTH-1:0] issue_rd,
  output logic              issue_stall,
  input  logic [AWIDTH-1:0] q_rs1,
  input  logic [AWIDTH-1:0] q_rs2,
  output logic              q_busy1,
  output logic              q_busy2
);

  localparam int NREGS = 1 << AWIDTH;
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  // The held entry uses the package struct, so widths must agree with it.
  if (AWIDTH != WB_AWIDTH || DWIDTH != WB_DWIDTH) begin : g_width_chk
    $error("wb_stage: AWIDTH/DWIDTH must match wb_stage_pkg");
  end

  logic              full;
  wb_entry_t         held;
  logic [DWIDTH-1:0] aligned;
  logic [DWIDTH-1:0] fmt_data;
  logic              fire_in;
  logic              inc;
  logic [CNTW-1:0]   cnt [NREGS];

  load_align #(.DWIDTH(DWIDTH)) u_align (
    .size         (in_load_size),
    .unsigned_ext (in_load_unsigned),
    .addr_lo      (in_addr_lo),
    .word         (in_result),
    .data         (aligned)
  );

  assign fmt_data     = in_is_load ? aligned : in_result;
  assign in_ready     = !full || retire_ready;
  assign fire_in      = in_valid && in_ready;
  assign retire_valid = full;
  assign retire_rd    = held.rd;
  assign retire_data  = held.data;

  // Write fires with the retire handshake, so a stalled entry writes once.
  // Gated by rst so a held entry is dropped without writing.
  assign rf_wen   = !rst && full && retire_ready && held.rd_wen && (held.rd != '0);
  assign rf_waddr = held.rd;
  assign rf_wdata = held.data;

  // Holding register: capture replaces a retiring entry in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      held <= '0;
    end else if (fire_in) begin
      full        <= 1'b1;
      held.rd     <= in_rd;
      held.rd_wen <= in_rd_wen;
      held.data   <= fmt_data;
    end else if (retire_ready) begin
      full <= 1'b0;
    end
  end

  assign issue_stall = (cnt[issue_rd] == CNT_MAX);
  assign inc         = issue_valid && (issue_rd != '0) && !issue_stall;
  assign q_busy1     = (cnt[q_rs1] != '0);
  assign q_busy2     = (cnt[q_rs2] != '0);

  // Scoreboard counters: +1 on issue, -1 on register-file write; x0 stays 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int i = 1; i < NREGS; i++) begin
        if (inc && issue_rd == AWIDTH'(i) && !(rf_wen && held.rd == AWIDTH'(i)))
          cnt[i] <= cnt[i] + 1'b1;
        else if (rf_wen && held.rd == AWIDTH'(i) && !(inc && issue_rd == AWIDTH'(i))
                 && cnt[i] != '0)
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  // A write for a register with no pending issue means upstream lost track.
  always_ff @(posedge clk) begin
    if (!rst && rf_wen && !(inc && issue_rd == held.rd))
      assert (cnt[held.rd] != '0) else $error("wb_stage: scoreboard underflow on x%0d", held.rd);
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: load formatting table, backpressure,
// streaming, scoreboard saturation, x0 handling and reset mid-hold.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_rd_wen, in_is_load, in_load_unsigned;
  logic [4:0]  in_rd;
  logic [1:0]  in_load_size, in_addr_lo;
  logic [31:0] in_result;
  logic        retire_valid, retire_ready;
  logic [4:0]  retire_rd;
  logic [31:0] retire_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        issue_valid, issue_stall;
  logic [4:0]  issue_rd, q_rs1, q_rs2;
  logic        q_busy1, q_busy2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .in_is_load(in_is_load), .in_load_size(in_load_size),
    .in_load_unsigned(in_load_unsigned), .in_addr_lo(in_addr_lo), .in_result(in_result),
    .retire_valid(retire_valid), .retire_ready(retire_ready), .retire_rd(retire_rd),
    .retire_data(retire_data), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_stall(issue_stall),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_busy1(q_busy1), .q_busy2(q_busy2)
  );

  typedef struct {
    logic        is_load;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  addr_lo;
    logic [31:0] result;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_rd    = rd;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic send(input logic [4:0] rd, input logic wen, input logic [31:0] d);
    in_valid   = 1'b1;
    in_rd      = rd;
    in_rd_wen  = wen;
    in_is_load = 1'b0;
    in_result  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 2'd0, 1'b0, 2'd3, 32'h80FF7F01, 32'hFFFFFF80};
    vecs[1]  = '{1'b1, 2'd0, 1'b1, 2'd3, 32'h80FF7F01, 32'h00000080};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 2'd0, 32'h80FF7F01, 32'h00000001};
    vecs[3]  = '{1'b1, 2'd0, 1'b0, 2'd1, 32'h80FF7F01, 32'h0000007F};
    vecs[4]  = '{1'b1, 2'd0, 1'b0, 2'd2, 32'h80FF7F01, 32'hFFFFFFFF};
    vecs[5]  = '{1'b1, 2'd1, 1'b0, 2'd2, 32'h80011234, 32'hFFFF8001};
    vecs[6]  = '{1'b1, 2'd1, 1'b0, 2'd3, 32'h80011234, 32'hFFFF8001};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 2'd0, 32'h80011234, 32'h00001234};
    vecs[8]  = '{1'b1, 2'd1, 1'b1, 2'd1, 32'h0000F00D, 32'h0000F00D};
    vecs[9]  = '{1'b1, 2'd2, 1'b0, 2'd1, 32'h80FF7F01, 32'h80FF7F01};
    vecs[10] = '{1'b1, 2'd3, 1'b0, 2'd2, 32'h80FF7F01, 32'h80FF7F01};
    vecs[11] = '{1'b0, 2'd0, 1'b0, 2'd3, 32'hDEADBEEF, 32'hDEADBEEF};

    rst = 1'b1; in_valid = 0; in_rd = 0; in_rd_wen = 0; in_is_load = 0;
    in_load_size = 0; in_load_unsigned = 0; in_addr_lo = 0; in_result = 0;
    retire_ready = 0; issue_valid = 0; issue_rd = 0; q_rs1 = 5'd7; q_rs2 = 5'd7;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_retire_valid", 32'(retire_valid), 32'd0);
    chk("rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("rst_busy1", 32'(q_busy1), 32'd0);
    chk("rst_stall", 32'(issue_stall), 32'd0);

    // Formatting table: rd_wen=0 so the scoreboard is untouched.
    retire_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_rd = 5'd1; in_rd_wen = 1'b0;
      in_is_load = vecs[i].is_load; in_load_size = vecs[i].size;
      in_load_unsigned = vecs[i].uns; in_addr_lo = vecs[i].addr_lo;
      in_result = vecs[i].result;
      tick();
      in_valid = 1'b0;
      #1;
      chk($sformatf("fmt%0d_valid", i), 32'(retire_valid), 32'd1);
      chk($sformatf("fmt%0d_data", i), retire_data, vecs[i].exp);
      chk($sformatf("fmt%0d_rf_wen", i), 32'(rf_wen), 32'd0);
    end
    in_load_size = 0; in_load_unsigned = 0; in_addr_lo = 0;
    tick();

    // Backpressure: rd=5 held for 3 cycles, then exactly one write.
    issue(5'd5);
    q_rs1 = 5'd5;
    retire_ready = 1'b0;
    send(5'd5, 1'b1, 32'h2A);
    for (int c = 0; c < 3; c++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_rf_wen", 32'(rf_wen), 32'd0);
      chk("bp_valid", 32'(retire_valid), 32'd1);
      chk("bp_busy", 32'(q_busy1), 32'd1);
      tick();
    end
    retire_ready = 1'b1;
    #1;
    chk("bp_wen", 32'(rf_wen), 32'd1);
    chk("bp_waddr", 32'(rf_waddr), 32'd5);
    chk("bp_wdata", rf_wdata, 32'h2A);
    tick();
    chk("bp_wen_once", 32'(rf_wen), 32'd0);
    chk("bp_busy_clr", 32'(q_busy1), 32'd0);

    // Streaming at one per cycle.
    issue(5'd1); issue(5'd2); issue(5'd3);
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1; in_rd = 5'(k); in_rd_wen = 1'b1; in_is_load = 1'b0;
      in_result = 32'(k * 32'h11);
      #1;
      chk("st_in_ready", 32'(in_ready), 32'd1);
      if (k > 1) begin
        chk("st_wen", 32'(rf_wen), 32'd1);
        chk("st_waddr", 32'(rf_waddr), 32'(k - 1));
        chk("st_wdata", rf_wdata, 32'((k - 1) * 32'h11));
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("st_last_waddr", 32'(rf_waddr), 32'd3);
    chk("st_last_wen", 32'(rf_wen), 32'd1);
    tick();
    chk("st_drained", 32'(retire_valid), 32'd0);

    // Scoreboard saturation on x7.
    q_rs1 = 5'd7; q_rs2 = 5'd7;
    issue(5'd7); issue(5'd7);
    chk("sb_busy1", 32'(q_busy1), 32'd1);
    chk("sb_busy2", 32'(q_busy2), 32'd1);
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    chk("sb_no_stall_at2", 32'(issue_stall), 32'd0);
    tick();
    chk("sb_stall_at3", 32'(issue_stall), 32'd1);
    tick();
    issue_valid = 1'b0;
    send(5'd7, 1'b1, 32'h70);
    send(5'd7, 1'b1, 32'h71);
    tick();
    chk("sb_cnt1_busy", 32'(q_busy1), 32'd1);
    chk("sb_cnt1_nostall", 32'(issue_stall), 32'd1 & 32'(issue_rd != 5'd7));
    send(5'd7, 1'b1, 32'h72);
    tick();
    chk("sb_cnt0_busy", 32'(q_busy1), 32'd0);

    // Same-cycle issue and retire of x7 keeps the count.
    issue(5'd7);
    send(5'd7, 1'b1, 32'h73);
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    chk("sb_same_wen", 32'(rf_wen), 32'd1);
    tick();
    issue_valid = 1'b0;
    #1;
    chk("sb_same_busy", 32'(q_busy1), 32'd1);
    send(5'd7, 1'b1, 32'h74);
    tick();
    chk("sb_same_drain", 32'(q_busy1), 32'd0);

    // x0: never written, never counted.
    q_rs1 = 5'd0; q_rs2 = 5'd0;
    issue(5'd0);
    chk("x0_busy1", 32'(q_busy1), 32'd0);
    chk("x0_busy2", 32'(q_busy2), 32'd0);
    in_valid = 1'b1; in_rd = 5'd0; in_rd_wen = 1'b1; in_result = 32'h55;
    tick();
    in_valid = 1'b0;
    #1;
    chk("x0_valid", 32'(retire_valid), 32'd1);
    chk("x0_rf_wen", 32'(rf_wen), 32'd0);
    tick();

    // Reset while an entry is held.
    q_rs1 = 5'd9;
    issue(5'd9);
    retire_ready = 1'b0;
    send(5'd9, 1'b1, 32'h99);
    chk("rh_held", 32'(retire_valid), 32'd1);
    rst = 1'b1; retire_ready = 1'b1;
    #1;
    chk("rh_no_wen", 32'(rf_wen), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rh_valid", 32'(retire_valid), 32'd0);
    chk("rh_busy", 32'(q_busy1), 32'd0);
    chk("rh_in_ready", 32'(in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
